// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: decode-stage control and hazard sequencer for the
// 5-stage pipeline. Decodes the IF/ID opcode into datapath controls, keeps a
// scoreboard of in-flight destination registers (EX..WB), stalls decode on RAW
// hazards (no forwarding in the datapath) and flushes the fetched slot after a
// jump.
// Optional build macro: HAZARD_PERF_COUNTERS_EN adds saturating stall/flush
// counters; without it stall_count and flush_count are tied to zero.
//
// Handshake: there is no valid/ready pair here. pc_hold/ifid_hold tell fetch to
// keep its state at the coming edge; ifid_flush tells IF/ID its slot is dead.
module pipeline_hazard_ctrl #(
    parameter int OP_W     = 8,
    parameter int RA_W     = 5,
    parameter int SB_DEPTH = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [OP_W-1:0] op,
    input  logic [RA_W-1:0] rs,
    input  logic [RA_W-1:0] rt,
    input  logic [RA_W-1:0] rd,
    output logic [3:0]      ALUOp,
    output logic [1:0]      ALUSrc,
    output logic            MemRead,
    output logic            MemWrite,
    output logic [1:0]      MemToReg,
    output logic            RegWrite,
    output logic            PCSrc,
    output logic            pc_hold,
    output logic            ifid_hold,
    output logic            ifid_flush,
    output logic            illegal_op,
    output logic [15:0]     stall_count,
    output logic [15:0]     flush_count
);

    logic                id_valid;
    logic [SB_DEPTH-1:0] sb_v;
    logic [RA_W-1:0]     sb_rd [SB_DEPTH];

    logic [3:0]      alu_op_d;
    logic [1:0]      alu_src_d;
    logic            mem_read_d;
    logic            mem_write_d;
    logic [1:0]      mem_to_reg_d;
    logic            reg_write_d;
    logic            pc_src_d;
    logic            use_rs;
    logic            use_rt;
    logic            legal;
    logic [OP_W-1:0] op_off;
    logic            src_hit;
    logic            hazard;
    logic            issue;

    // Raw decode of the IF/ID opcode, before validity and hazard gating
    always_comb begin
        alu_op_d     = '0;
        alu_src_d    = '0;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_to_reg_d = '0;
        reg_write_d  = 1'b0;
        pc_src_d     = 1'b0;
        use_rs       = 1'b0;
        use_rt       = 1'b0;
        legal        = 1'b1;
        op_off       = '0;
        case (op) inside
            8'h00: ;
            [8'h01:8'h09]: begin
                op_off       = op - 8'h01;
                alu_op_d     = op_off[3:0];
                mem_to_reg_d = 2'b01;
                reg_write_d  = 1'b1;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            [8'h11:8'h19]: begin
                op_off       = op - 8'h11;
                alu_op_d     = op_off[3:0];
                alu_src_d    = 2'b01;
                mem_to_reg_d = 2'b01;
                reg_write_d  = 1'b1;
                use_rs       = 1'b1;
            end
            [8'h27:8'h29]: begin
                // shamt shifts reuse the R-type SLL/SRA/SRL codes 6..8
                op_off       = op - 8'h21;
                alu_op_d     = op_off[3:0];
                alu_src_d    = 2'b10;
                mem_to_reg_d = 2'b01;
                reg_write_d  = 1'b1;
                use_rs       = 1'b1;
            end
            8'h20: begin
                alu_src_d    = 2'b01;
                mem_read_d   = 1'b1;
                mem_to_reg_d = 2'b00;
                reg_write_d  = 1'b1;
                use_rs       = 1'b1;
            end
            8'h21: begin
                alu_src_d    = 2'b01;
                mem_write_d  = 1'b1;
                use_rs       = 1'b1;
                use_rt       = 1'b1;
            end
            8'h30: pc_src_d = 1'b1;
            8'h31: begin
                pc_src_d     = 1'b1;
                mem_to_reg_d = 2'b10;
                reg_write_d  = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // RAW check of used sources against every valid in-flight destination;
    // the WB entry is included because the RF write is not visible to decode
    always_comb begin
        src_hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_v[i] && ((use_rs && (sb_rd[i] == rs)) || (use_rt && (sb_rd[i] == rt))))
                src_hit = 1'b1;
        end
    end

    assign hazard = id_valid && src_hit;
    assign issue  = id_valid && !src_hit;

    // Controls leave as a bubble unless the instruction actually issues
    assign ALUOp      = issue ? alu_op_d     : '0;
    assign ALUSrc     = issue ? alu_src_d    : '0;
    assign MemRead    = issue && mem_read_d;
    assign MemWrite   = issue && mem_write_d;
    assign MemToReg   = issue ? mem_to_reg_d : '0;
    assign RegWrite   = issue && reg_write_d;
    assign PCSrc      = issue && pc_src_d;
    assign pc_hold    = hazard;
    assign ifid_hold  = hazard;
    assign ifid_flush = issue && pc_src_d;

    // Slot validity, scoreboard shift and sticky illegal-opcode flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_valid   <= 1'b0;
            illegal_op <= 1'b0;
            sb_v       <= '0;
            for (int i = 0; i < SB_DEPTH; i++) sb_rd[i] <= '0;
        end else begin
            id_valid <= !ifid_flush;
            sb_v[0]  <= issue && reg_write_d;
            sb_rd[0] <= rd;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
            if (issue && !legal) illegal_op <= 1'b1;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    // Saturating event counters for hazard cycles and slot flushes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (hazard && (stall_q != 16'hFFFF))     stall_q <= stall_q + 16'd1;
            if (ifid_flush && (flush_q != 16'hFFFF)) flush_q <= flush_q + 16'd1;
        end
    end

    assign stall_count = stall_q;
    assign flush_count = flush_q;
`else
    assign stall_count = '0;
    assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. The bench plays the IF/ID
// register: it keeps the instruction fields steady while ifid_hold is high.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_PERF_COUNTERS_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [3:0]  ALUOp;
    logic [1:0]  ALUSrc;
    logic        MemRead, MemWrite;
    logic [1:0]  MemToReg;
    logic        RegWrite, PCSrc;
    logic        pc_hold, ifid_hold, ifid_flush, illegal_op;
    logic [15:0] stall_count, flush_count;

    int tests = 0;
    int fails = 0;

    // {ALUOp, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, PCSrc}
    wire [11:0] ctrl = {ALUOp, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, PCSrc};

    localparam logic [11:0] C_NONE = 12'b0000_00_0_0_00_0_0;
    localparam logic [11:0] C_ADD  = 12'b0000_00_0_0_01_1_0;
    localparam logic [11:0] C_SUB  = 12'b0001_00_0_0_01_1_0;
    localparam logic [11:0] C_LW   = 12'b0000_01_1_0_00_1_0;
    localparam logic [11:0] C_JAL  = 12'b0000_00_0_0_10_1_1;

    pipeline_hazard_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .rs(rs), .rt(rt), .rd(rd),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .MemRead(MemRead), .MemWrite(MemWrite),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .PCSrc(PCSrc),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .ifid_flush(ifid_flush),
        .illegal_op(illegal_op), .stall_count(stall_count), .flush_count(flush_count)
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [7:0] o, input logic [4:0] s, input logic [4:0] t,
                             input logic [4:0] d);
        op = o; rs = s; rt = t; rd = d;
        #1;
    endtask

    task automatic test_reset_add();
        reset = 1'b0;
        set_instr(8'h01, 5'd1, 5'd2, 5'd3);
        tests++;
        if (ctrl !== C_NONE || pc_hold !== 1'b0 || ifid_flush !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got %h hold %b flush %b, want %h 0 0", ctrl, pc_hold, ifid_flush, C_NONE);
        end
        tests++;
        if (illegal_op !== 1'b0 || stall_count !== 16'd0 || flush_count !== 16'd0) begin
            fails++; $display("FAIL reset_state: illegal %b stalls %0d flushes %0d, want 0 0 0", illegal_op, stall_count, flush_count);
        end
        #3 reset = 1'b1;
        #1;
        tests++;
        if (ctrl !== C_NONE) begin
            fails++; $display("FAIL first_slot: got %h want %h", ctrl, C_NONE);
        end
        tick();
        tests++;
        if (ctrl !== C_ADD || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL add_issue: got %h hold %b, want %h 0", ctrl, ifid_hold, C_ADD);
        end
    endtask

    task automatic test_raw_3();
        int n;
        tick();
        set_instr(8'h02, 5'd3, 5'd5, 5'd4);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (!ifid_hold) break;
            n++;
            tests++;
            if (ctrl !== C_NONE || pc_hold !== 1'b1 || ifid_flush !== 1'b0) begin
                fails++; $display("FAIL raw3_bubble: got %h pc_hold %b flush %b", ctrl, pc_hold, ifid_flush);
            end
            tick();
        end
        tests++;
        if (n != 3) begin
            fails++; $display("FAIL raw3_len: got %0d want 3", n);
        end
        tests++;
        if (ctrl !== C_SUB) begin
            fails++; $display("FAIL sub_issue: got %h want %h", ctrl, C_SUB);
        end
        tests++;
        if (stall_count !== (PERF ? 16'd3 : 16'd0)) begin
            fails++; $display("FAIL stall_count3: got %0d want %0d", stall_count, PERF ? 3 : 0);
        end
    endtask

    task automatic test_load_use();
        int n;
        tick();
        set_instr(8'h20, 5'd1, 5'd0, 5'd7);
        tests++;
        if (ctrl !== C_LW || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL lw_issue: got %h hold %b, want %h 0", ctrl, ifid_hold, C_LW);
        end
        tick();
        set_instr(8'h00, 5'd0, 5'd0, 5'd0);
        tests++;
        if (ctrl !== C_NONE || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL nop_issue: got %h hold %b", ctrl, ifid_hold);
        end
        tick();
        set_instr(8'h01, 5'd7, 5'd1, 5'd8);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            if (!ifid_hold) break;
            n++;
            tick();
        end
        tests++;
        if (n != 2) begin
            fails++; $display("FAIL loaduse_len: got %0d want 2", n);
        end
        tests++;
        if (ctrl !== C_ADD) begin
            fails++; $display("FAIL loaduse_add: got %h want %h", ctrl, C_ADD);
        end
        tests++;
        if (stall_count !== (PERF ? 16'd5 : 16'd0)) begin
            fails++; $display("FAIL stall_count5: got %0d want %0d", stall_count, PERF ? 5 : 0);
        end
    endtask

    task automatic test_jal_flush();
        tick();
        set_instr(8'h31, 5'd0, 5'd0, 5'd31);
        tests++;
        if (ctrl !== C_JAL || ifid_flush !== 1'b1 || pc_hold !== 1'b0) begin
            fails++; $display("FAIL jal_issue: got %h flush %b hold %b, want %h 1 0", ctrl, ifid_flush, pc_hold, C_JAL);
        end
        tick();
        set_instr(8'h01, 5'd1, 5'd2, 5'd9);
        tests++;
        if (ctrl !== C_NONE || ifid_flush !== 1'b0 || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL jal_shadow: got %h flush %b hold %b, want %h 0 0", ctrl, ifid_flush, ifid_hold, C_NONE);
        end
        tests++;
        if (flush_count !== (PERF ? 16'd1 : 16'd0)) begin
            fails++; $display("FAIL flush_count1: got %0d want %0d", flush_count, PERF ? 1 : 0);
        end
        tick();
        tests++;
        if (ctrl !== C_ADD || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL post_jal_add: got %h hold %b, want %h 0", ctrl, ifid_hold, C_ADD);
        end
    endtask

    task automatic test_decode();
        logic [7:0]  ops  [6] = '{8'h13, 8'h28, 8'h21, 8'h19, 8'h09, 8'h30};
        logic [11:0] exps [6] = '{12'b0010_01_0_0_01_1_0, 12'b0111_10_0_0_01_1_0,
                                  12'b0000_01_0_1_00_0_0, 12'b1000_01_0_0_01_1_0,
                                  12'b1000_00_0_0_01_1_0, 12'b0000_00_0_0_00_0_1};
        for (int i = 0; i < 6; i++) begin
            tick();
            set_instr(ops[i], 5'd1, 5'd2, 5'(20 + i));
            tests++;
            if (ctrl !== exps[i] || ifid_hold !== 1'b0 || ifid_flush !== (i == 5)) begin
                fails++; $display("FAIL decode_%h: got %h hold %b flush %b, want %h", ops[i], ctrl, ifid_hold, ifid_flush, exps[i]);
            end
        end
        tick();
        set_instr(8'h01, 5'd1, 5'd2, 5'd10);
        tests++;
        if (ctrl !== C_NONE) begin
            fails++; $display("FAIL j_shadow: got %h want %h", ctrl, C_NONE);
        end
        tests++;
        if (flush_count !== (PERF ? 16'd2 : 16'd0)) begin
            fails++; $display("FAIL flush_count2: got %0d want %0d", flush_count, PERF ? 2 : 0);
        end
    endtask

    task automatic test_illegal();
        tick();
        set_instr(8'h5A, 5'd0, 5'd0, 5'd12);
        tests++;
        if (ctrl !== C_NONE || ifid_hold !== 1'b0 || illegal_op !== 1'b0) begin
            fails++; $display("FAIL illegal_decode: got %h hold %b illegal %b, want %h 0 0", ctrl, ifid_hold, illegal_op, C_NONE);
        end
        tick();
        set_instr(8'h01, 5'd12, 5'd12, 5'd13);
        tests++;
        if (illegal_op !== 1'b1) begin
            fails++; $display("FAIL illegal_set: got %b want 1", illegal_op);
        end
        tests++;
        if (ctrl !== C_ADD || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL illegal_no_sb: got %h hold %b, want %h 0", ctrl, ifid_hold, C_ADD);
        end
        tick();
        set_instr(8'h00, 5'd0, 5'd0, 5'd0);
        tests++;
        if (illegal_op !== 1'b1) begin
            fails++; $display("FAIL illegal_sticky: got %b want 1", illegal_op);
        end
    endtask

    task automatic test_reset_mid_stall();
        tick();
        set_instr(8'h01, 5'd1, 5'd2, 5'd13);
        tick();
        set_instr(8'h02, 5'd13, 5'd0, 5'd14);
        tests++;
        if (ifid_hold !== 1'b1 || ctrl !== C_NONE) begin
            fails++; $display("FAIL mid_stall_enter: hold %b ctrl %h, want 1 %h", ifid_hold, ctrl, C_NONE);
        end
        tick();
        reset = 1'b0;
        #1;
        tests++;
        if (ctrl !== C_NONE || ifid_hold !== 1'b0 || illegal_op !== 1'b0 ||
            stall_count !== 16'd0 || flush_count !== 16'd0) begin
            fails++; $display("FAIL async_reset: ctrl %h hold %b illegal %b stalls %0d flushes %0d", ctrl, ifid_hold, illegal_op, stall_count, flush_count);
        end
        #2 reset = 1'b1;
        tick();
        tests++;
        if (ctrl !== C_SUB || ifid_hold !== 1'b0) begin
            fails++; $display("FAIL post_reset_sub: got %h hold %b, want %h 0", ctrl, ifid_hold, C_SUB);
        end
    endtask

    initial begin
        op = '0; rs = '0; rt = '0; rd = '0; reset = 1'b0;
        #2;
        test_reset_add();
        test_raw_3();
        test_load_use();
        test_jal_flush();
        test_decode();
        test_illegal();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Control and hazard sequencer for the 5-stage 32-bit pipelined datapath.
- Decodes the 8-bit opcode in decode into datapath control (ALUOp, ALUSrc, MemRead, MemWrite, MemToReg, RegWrite, PCSrc).
- Tracks in-flight destination registers in a scoreboard and stalls decode on RAW hazards; the datapath has no forwarding.
- Flushes the fetched slot after a jump and suppresses the garbage IF/ID contents present after reset.

Parameters:
- OP_W, 8, opcode width (instruction[7:0]).
- RA_W, 5, register address width.
- SB_DEPTH, 3, stages from EX through WB that hold a pending RF write.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- op  in  OP_W  IF/ID instruction[7:0].
- rs  in  RA_W  IF/ID instruction[26:22].
- rt  in  RA_W  IF/ID instruction[21:17].
- rd  in  RA_W  IF/ID instruction[31:27].
- ALUOp  out  4  ALU function to ID/EX.
- ALUSrc  out  2  00 db, 01 sign-extended immediate, 10 shamt.
- MemRead  out  1  load.
- MemWrite  out  1  store.
- MemToReg  out  2  00 memory, 01 ALU, 10 PC+4.
- RegWrite  out  1  RF write.
- PCSrc  out  1  take JumpAddress.
- pc_hold  out  1  PC keeps its value this edge.
- ifid_hold  out  1  IF/ID keeps its value this edge.
- ifid_flush  out  1  IF/ID slot is invalidated this edge.
- illegal_op  out  1  sticky; set by an undefined opcode.
- stall_count  out  16  stall cycles, saturating.
- flush_count  out  16  flushes, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - id_valid=0, all scoreboard entries invalid, illegal_op=0, counters=0.
  - All control outputs are 0 while reset is asserted and while id_valid=0.
- id_valid:
  - Set to 1 at the first rising edge after reset deasserts.
  - Cleared for one cycle following any edge at which ifid_flush=1.
  - Held while ifid_hold=1.
- Decode table, valid only when id_valid=1:
  - 0x00 NOP: all controls 0.
  - 0x01-0x09 R-type ADD, SUB, MUL, XOR, OR, AND, SLL, SRA, SRL: ALUOp=op-1, ALUSrc=00, MemToReg=01, RegWrite=1. Sources rs, rt.
  - 0x11-0x19 immediate forms of the same ALU ops: ALUOp=op-0x11, ALUSrc=01, MemToReg=01, RegWrite=1. Source rs.
  - 0x27/0x28/0x29 shift by shamt (SLL, SRA, SRL): ALUOp=6/7/8 respectively, ALUSrc=10, MemToReg=01, RegWrite=1. Source rs.
  - 0x20 LW: ALUOp=0, ALUSrc=01, MemRead=1, MemToReg=00, RegWrite=1. Source rs.
  - 0x21 SW: ALUOp=0, ALUSrc=01, MemWrite=1. Sources rs, rt.
  - 0x30 J: PCSrc=1. No sources.
  - 0x31 JAL: PCSrc=1, MemToReg=10, RegWrite=1. No sources.
  - Any other opcode: treated as NOP; illegal_op set at the next edge and stays set until reset.
- Scoreboard:
  - SB_DEPTH entries {v, rd}, shifting one position per edge, every edge, including during stalls.
  - Entry 0 loads {RegWrite, rd} of the instruction issued this cycle; loads {0, x} when a bubble is issued.
  - The last entry (WB) is compared: the RF write at the WB edge is not visible to the combinational RF read in decode.
- Hazard:
  - hazard = id_valid AND a used source equals the rd of any valid scoreboard entry.
  - Register 0 is not special.
- On hazard:
  - pc_hold=1, ifid_hold=1.
  - All control outputs forced to 0 (bubble); this includes PCSrc.
  - A pending jump is not taken until its own hazard clears.
- Stall length: 3 cycles if the producer is directly ahead, 2 if one instruction separates them, 1 if two separate them, 0 if three or more.
- Jump issued (PCSrc=1, no hazard):
  - ifid_flush=1 for that cycle, so the next decode slot is a bubble.
  - No hold.
- Simultaneous events:
  - Hazard has priority over flush.
  - An illegal opcode under a hazard is flagged only when it actually issues.
- Reset mid-stall: scoreboard and id_valid are cleared immediately; no RegWrite leaks out.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- When defined:
  - stall_count increments on each hazard cycle.
  - flush_count increments on each ifid_flush cycle.
  - Both are 16-bit, saturate at 0xFFFF, and clear on reset.
- When undefined: both ports are tied to 0 and no counter registers are synthesized.

Test Plan:
- Reset release, then ADD r3,r1,r2 (op 0x01):
  - cycle 0 after release: all controls 0.
  - next cycle: ALUOp=0, ALUSrc=00, RegWrite=1, MemToReg=01, no hold.
- ADD r3 followed immediately by SUB r4,r3,r5:
  - pc_hold=ifid_hold=1 for exactly 3 cycles with bubble controls.
  - SUB then issues ALUOp=1.
  - stall_count=3 when enabled.
- LW r7 ; NOP ; ADD r8,r7,r1 -> exactly 2 stall cycles. LW issues MemRead=1, MemToReg=00.
- JAL r31 (op 0x31):
  - PCSrc=1, MemToReg=10, RegWrite=1, ifid_flush=1 for one cycle.
  - the following slot decodes as NOP regardless of the op input.
  - flush_count=1.
- op 0x5A -> all controls 0 and no scoreboard entry; illegal_op=1 from the next edge, held until reset=0.
- Assert reset during a 3-cycle stall:
  - outputs go 0 asynchronously.
  - after release, a dependent instruction issues without stalling.
